r4booth_mul_pipe: RTL and testbench
===================================

# r4booth_mul_pipe

Parametrised, fully pipelined radix-4 Booth multiplier with per-operation signed/unsigned mode, valid/ready flow control and a sideband tag. It is the general-width successor to the fixed 12-bit Booth datapath in the nonlinear-approximation engine. It feeds the polynomial/approximation stages, which need back-to-back products at one per cycle with backpressure.

## Interface
- N, 16: operand width; even, ≥4.
- TAG_W, 4: sideband tag width; ≥1.
- clkn_i  in  1  clock; all registers update on its falling edge.
- rstn_i  in  1  reset; synchronous, active-high. Sampled at the falling edge of clkn_i.
- valid_i  in  1  operand pair present.
- ready_o  out  1  block can accept this cycle.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- multiplicand_i  in  N  operand A.
- multiplier_i  in  N  operand B (Booth-recoded).
- tag_i  in  TAG_W  carried unchanged alongside the operation.
- valid_o  out  1  product_o/tag_o valid.
- ready_i  in  1  downstream accepts.
- product_o  out  2N  A×B, exact.
- tag_o  out  TAG_W  tag of the operation on product_o.

## Operation
- Four register stages, each with its own valid bit:
  - S0: operand capture.
  - S1: partial-product registers.
  - S2: pair-sum registers.
  - S3: output registers product_o/tag_o/valid_o.
- Operand extension:
  - Multiplicand extends to N+2 bits; multiplier becomes {ext, ext, B, 1'b0}.
  - ext = sign bit of the operand when signed_i = 1, else 0.
  - signed_i is captured with the operands in S0.
- Recoding: G = N/2+1 overlapping triplets, bits [2k+2:2k] for k = 0..N/2.
  - 000, 111 → 0
  - 001, 010 → +A
  - 011 → +2A
  - 100 → −2A
  - 101, 110 → −A
- Each partial product is sign-extended to 2N bits and pre-shifted left by 2k before registering in S1.
- In signed mode the top triplet is always 000 or 111, so its partial product is 0.
- S2: P = ceil(G/2) sums, pp[2j] + pp[2j+1]. An unpaired last pp passes through unchanged. Arithmetic is mod 2^(2N).
- S3: product = sum of the P pair-sums, mod 2^(2N).
  - Result equals the exact signed or unsigned product. No truncation or rounding.
- Flow control: stall = valid_o & ~ready_i; ready_o = ~stall.
  - On stall, every stage holds its data and valid bits.
  - Otherwise all stages advance. Empty slots (bubbles) advance as invalid; they are not compressed.
- A transfer occurs on the input when valid_i & ready_o. On the output it occurs when valid_o & ready_i.
- The tag and mode bit travel with their data through every stage.

## Timing
- Reset (rstn_i = 1 at a falling edge):
  - All stage valids clear; valid_o = 0.
  - product_o = 0, tag_o = 0.
  - ready_o = 1 combinationally from the next cycle.
  - In-flight operations are discarded, with no partial output.
- Reset has priority over stall and over valid_i.
- Latency: an operation accepted at falling edge E appears on product_o/valid_o after edge E+3, provided no stall occurs in between.
- Each stalled edge adds one cycle.
- Throughput: one operation per cycle when ready_i stays high.
- ready_o depends combinationally on valid_o and ready_i only, never on valid_i.
- When valid_o = 1 and ready_i = 1 at the same time as valid_i = 1, the output retires and the new operand is accepted on the same edge.
- While valid_o = 0 the pipeline never stalls, even when ready_i = 0.
- Held outputs stay bit-stable during a stall.

## Test plan
- Unsigned, N = 16: A = 0xFFFF, B = 0xFFFF → product_o = 0xFFFE0001. Also 0x1234 × 0x5678 → 0x06260060, valid_o after E+3.
- Signed, N = 16:
  - 0x8000 × 0x8000 → 0x40000000.
  - 0xFFFF × 0x0001 → 0xFFFFFFFF.
  - 0x8000 × 0x7FFF → 0xC0008000.
  - The same bit patterns in unsigned mode give the unsigned products.
- Stream: 8 back-to-back ops with tags 0..7 and alternating mode.
  - Drop ready_i for 3 cycles mid-stream, so ready_o = 0 for those cycles.
  - Required: outputs in order, tags match, no loss or duplication, product_o stable while stalled.
- Reset mid-operation: accept 3 ops, then assert rstn_i for 1 cycle.
  - Required: valid_o = 0, product_o = 0, no stale result afterwards.
  - The next op is accepted immediately and completes after E+3.
- N = 6, TAG_W = 1: exhaustive 64×64×2 modes against a reference model, with random ready_i.
- N = 12: random signed/unsigned operands and random valid_i/ready_i for 10k ops, scoreboarded.

Source files
------------

// File: rtl/r4booth_mul_pipe.sv
// Four-stage radix-4 Booth multiplier: operand capture, Booth partial products,
// pair sums, final sum. Signed/unsigned per operation, valid/ready with a tag.

module r4booth_pp #(
  parameter int N = 16,
  parameter int K = 0
) (
  input  logic [N+1:0]   a_ext_i,
  input  logic [2:0]     trip_i,
  output logic [2*N-1:0] pp_o
);
  logic [2*N-1:0] a_se, val;

  assign a_se = {{(N-2){a_ext_i[N+1]}}, a_ext_i};

  always_comb begin
    unique case (trip_i)
      3'b001, 3'b010: val = a_se;
      3'b011:         val = a_se << 1;
      3'b100:         val = -(a_se << 1);
      3'b101, 3'b110: val = -a_se;
      default:        val = '0;
    endcase
  end

  assign pp_o = val << (2 * K);
endmodule

module r4booth_mul_pipe #(
  parameter int N     = 16,
  parameter int TAG_W = 4
) (
  input  logic             clkn_i,
  input  logic             rstn_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             signed_i,
  input  logic [N-1:0]     multiplicand_i,
  input  logic [N-1:0]     multiplier_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [2*N-1:0]   product_o,
  output logic [TAG_W-1:0] tag_o
);
  localparam int G      = N / 2 + 1;
  localparam int P      = (G + 1) / 2;
  localparam int STAGES = 4;

  logic [STAGES-1:0]             vld_pipe_q;
  logic [STAGES-1:0][TAG_W-1:0]  tag_pipe_q;
  logic [N-1:0]                  a_q, b_q;
  logic                          sgn_q;
  logic [G-1:0][2*N-1:0]         pp_d, pp_q;
  logic [P-1:0][2*N-1:0]         ps_d, ps_q;
  logic [2*N-1:0]                prod_d, prod_q;
  logic                          stall;
  logic                          ext_a, ext_b;
  logic [N+1:0]                  a_ext;
  logic [N+2:0]                  b_ext;

  assign stall   = vld_pipe_q[STAGES-1] & ~ready_i;
  assign ready_o = ~stall;

  assign ext_a = sgn_q & a_q[N-1];
  assign ext_b = sgn_q & b_q[N-1];
  assign a_ext = {ext_a, ext_a, a_q};
  assign b_ext = {ext_b, ext_b, b_q, 1'b0};

  // One recoder per overlapping multiplier triplet
  for (genvar k = 0; k < G; k++) begin : g_pp
    r4booth_pp #(.N(N), .K(k)) u_pp (
      .a_ext_i (a_ext),
      .trip_i  (b_ext[2*k+2:2*k]),
      .pp_o    (pp_d[k])
    );
  end

  for (genvar j = 0; j < P; j++) begin : g_ps
    if (2 * j + 1 < G) begin : g_pair
      assign ps_d[j] = pp_q[2*j] + pp_q[2*j+1];
    end else begin : g_pass
      assign ps_d[j] = pp_q[2*j];
    end
  end

  always_comb begin
    prod_d = '0;
    for (int j = 0; j < P; j++) prod_d = prod_d + ps_q[j];
  end

  always_ff @(negedge clkn_i) begin
    if (rstn_i) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sgn_q      <= 1'b0;
      pp_q       <= '0;
      ps_q       <= '0;
      prod_q     <= '0;
    end else if (!stall) begin
      // Bubbles shift along with data; nothing is compressed
      vld_pipe_q <= {vld_pipe_q[STAGES-2:0], valid_i};
      tag_pipe_q <= {tag_pipe_q[STAGES-2:0], tag_i};
      a_q        <= multiplicand_i;
      b_q        <= multiplier_i;
      sgn_q      <= signed_i;
      pp_q       <= pp_d;
      ps_q       <= ps_d;
      prod_q     <= prod_d;
    end
  end

  assign valid_o   = vld_pipe_q[STAGES-1];
  assign tag_o     = tag_pipe_q[STAGES-1];
  assign product_o = prod_q;
endmodule

// File: tb/tb_r4booth_mul_pipe.sv
// Scoreboarded bench for r4booth_mul_pipe: directed products, stalled stream,
// mid-flight reset and a randomized run with random backpressure.

module tb_r4booth_mul_pipe;
  localparam int N  = 16;
  localparam int TW = 4;
  localparam int W  = 2 * N;

  logic          clkn = 1'b0, rstn = 1'b1, valid_i = 1'b0, signed_i = 1'b0, ready_i = 1'b1;
  logic [N-1:0]  a = '0, b = '0;
  logic [TW-1:0] tag_i = '0;
  logic          ready_o, valid_o;
  logic [W-1:0]  product_o;
  logic [TW-1:0] tag_o;

  typedef struct packed {
    logic [W-1:0]  p;
    logic [TW-1:0] t;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0;
  bit   rdy_rand = 1'b0, rdy_force = 1'b1;

  always #5 clkn = ~clkn;

  r4booth_mul_pipe #(.N(N), .TAG_W(TW)) dut (
    .clkn_i         (clkn),
    .rstn_i         (rstn),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .signed_i       (signed_i),
    .multiplicand_i (a),
    .multiplier_i   (b),
    .tag_i          (tag_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .product_o      (product_o),
    .tag_o          (tag_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
    end else begin
      sx = longint'({1'b0, x});
      sy = longint'({1'b0, y});
    end
    return W'(sx * sy);
  endfunction

  function automatic logic [N-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return N'(1) << (N - 1);
      3:       return (N'(1) << (N - 1)) - N'(1);
      default: return N'($urandom);
    endcase
  endfunction

  initial forever begin
    @(negedge clkn);
    #2;
    ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  initial begin : monitor
    bit            sp;
    logic [W-1:0]  pp;
    logic [TW-1:0] pt;
    exp_t          e;
    sp = 1'b0;
    pp = '0;
    pt = '0;
    forever begin
      @(posedge clkn);
      if (rstn) sp = 1'b0;
      else begin
        chk("ready_o", ready_o, !(valid_o && !ready_i));
        if (sp) begin
          chk("hold_product", product_o, pp);
          chk("hold_tag", tag_o, pt);
          chk("hold_valid", valid_o, 1);
        end
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: got product %0h tag %0h, expected no output", product_o, tag_o);
          end else begin
            e = q.pop_front();
            chk("product", product_o, e.p);
            chk("tag", tag_o, e.t);
          end
        end
        sp = valid_o && !ready_i;
        pp = product_o;
        pt = tag_o;
      end
    end
  end

  task automatic issue(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                       input logic [TW-1:0] t, input logic [W-1:0] e);
    int n;
    n = 0;
    valid_i = 1'b1; a = x; b = y; signed_i = s; tag_i = t;
    forever begin
      @(posedge clkn);
      if (ready_o) begin
        q.push_back(exp_t'{p: e, t: t});
        break;
      end
      n++;
      if (n > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL accept_timeout: ready_o low for %0d cycles, expected 1", n);
        break;
      end
    end
    @(negedge clkn);
    #1;
    valid_i = 1'b0;
  endtask

  // Single op into an empty pipe: valid_o must rise exactly after edge E+3
  task automatic single(input logic [N-1:0] x, input logic [N-1:0] y, input logic s,
                        input logic [TW-1:0] t, input logic [W-1:0] e);
    issue(x, y, s, t, e);
    @(negedge clkn);
    @(negedge clkn);
    @(posedge clkn);
    chk("latency_early", valid_o, 0);
    @(negedge clkn);
    @(posedge clkn);
    chk("latency_e3", valid_o, 1);
    @(negedge clkn);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 1000) begin
      @(negedge clkn);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (4) @(negedge clkn);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] x, y;
    logic         s;
    rstn = 1'b1;
    repeat (2) @(negedge clkn);
    #1 rstn = 1'b0;
    @(posedge clkn);
    chk("rst_valid", valid_o, 0);
    chk("rst_product", product_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_ready", ready_o, 1);
    @(negedge clkn);
    #1;

    single(16'hFFFF, 16'hFFFF, 1'b0, 4'd1, 32'hFFFE0001);
    single(16'h1234, 16'h5678, 1'b0, 4'd2, 32'h06260060);
    single(16'h8000, 16'h8000, 1'b1, 4'd3, 32'h40000000);
    single(16'hFFFF, 16'h0001, 1'b1, 4'd4, 32'hFFFFFFFF);
    single(16'h8000, 16'h7FFF, 1'b1, 4'd5, 32'hC0008000);
    single(16'h8000, 16'h8000, 1'b0, 4'd6, 32'h40000000);
    single(16'hFFFF, 16'h0001, 1'b0, 4'd7, 32'h0000FFFF);
    single(16'h8000, 16'h7FFF, 1'b0, 4'd8, 32'h3FFF8000);
    single(16'hFFFF, 16'hFFFF, 1'b1, 4'd9, 32'h00000001);

    fork
      for (int i = 0; i < 8; i++) begin
        x = pick(); y = pick(); s = i[0];
        issue(x, y, s, TW'(i), model(x, y, s));
      end
      begin
        repeat (5) @(negedge clkn);
        #1 rdy_force = 1'b0;
        repeat (3) begin
          @(posedge clkn);
          chk("stall_ready_o", ready_o, 0);
          @(negedge clkn);
        end
        #1 rdy_force = 1'b1;
      end
    join
    drain();

    for (int i = 0; i < 3; i++) begin
      x = pick(); y = pick(); s = i[0];
      issue(x, y, s, TW'(i + 10), model(x, y, s));
    end
    rstn = 1'b1;
    q.delete();
    @(negedge clkn);
    #1 rstn = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_product", product_o, 0);
    chk("midrst_tag", tag_o, 0);
    chk("midrst_ready", ready_o, 1);
    single(16'h1234, 16'h5678, 1'b1, 4'd13, 32'h06260060);
    drain();

    rdy_rand = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clkn);
        #1;
      end
      x = pick(); y = pick(); s = 1'($urandom);
      issue(x, y, s, TW'($urandom), model(x, y, s));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
